// File: rtl/dat_mem_copier_if.sv
// Copier bus: copy request/status plus data-memory port.
// slave = copier side, master = requester/memory side.
interface dat_mem_copier_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  start,
        input  src_addr,
        input  dst_addr,
        input  len,
        input  mem_rdata,
        output busy,
        output done,
        output mem_addr,
        output mem_wr_en,
        output mem_wdata
    );

    modport master (
        output start,
        output src_addr,
        output dst_addr,
        output len,
        output mem_rdata,
        input  busy,
        input  done,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata
    );
endinterface

// File: rtl/dat_mem_copier.sv
// Byte-by-byte memory copier: one read then one write per byte.
// Ports: clk, rst_n (async low), bus (dat_mem_copier_if.slave).
module dat_mem_copier #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dat_mem_copier_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode from the registered state only, so an
    // asynchronous reset drops mem_wr_en in the same instant.
    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wdata = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    src_d = bus.src_addr;
                    dst_d = bus.dst_addr;
                    cnt_d = bus.len;
                    if (bus.len != '0) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_q;
                data_d       = bus.mem_rdata;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                bus.busy      = 1'b1;
                bus.mem_addr  = dst_q;
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = data_q;
                // Pointers wrap naturally at 2^AW.
                src_d = src_q + AW'(1);
                dst_d = dst_q + AW'(1);
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dat_mem_copier.sv
// Self-checking bench for dat_mem_copier.
// Reference model: per-cycle expectation queue plus shadow memory.
module tb_dat_mem_copier;

    logic clk;
    logic rst_n;

    dat_mem_copier_if #(.AW(8), .DW(8)) bif ();

    dat_mem_copier #(.AW(8), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       clr;
    logic       tb_we;
    logic [7:0] tb_wa;
    logic [7:0] tb_wd;
    logic       pend_v;
    logic [7:0] pend_a;
    logic [7:0] pend_d;

    int n_chk;
    int n_fail;

    typedef enum {K_RD, K_WR, K_DN, K_IDLE} kind_e;
    typedef struct {
        kind_e      k;
        logic [7:0] s;
        logic [7:0] d;
    } ent_t;
    ent_t q[$];

    function automatic logic [7:0] patt(int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    assign bif.mem_rdata = mem[bif.mem_addr];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]     <= patt(i);
                ref_mem[i] <= patt(i);
            end
        end else begin
            if (bif.mem_wr_en) mem[bif.mem_addr] <= bif.mem_wdata;
            if (tb_we) begin
                mem[tb_wa]     <= tb_wd;
                ref_mem[tb_wa] <= tb_wd;
            end
            if (pend_v && rst_n) ref_mem[pend_a] <= pend_d;
        end
    end

    // Expected behaviour of one copy, cycle by cycle after start.
    function automatic void push_copy(logic [7:0] s, logic [7:0] d,
                                      logic [7:0] l);
        ent_t e;
        for (int k = 0; k < int'(l); k++) begin
            e.k = K_RD; e.s = 8'(s + k); e.d = 8'(d + k);
            q.push_back(e);
            e.k = K_WR;
            q.push_back(e);
        end
        e.k = K_DN; e.s = 8'h00; e.d = 8'h00;
        q.push_back(e);
    endfunction

    ent_t       ce;
    logic       eb, ed, ew;
    logic [7:0] ea, ewd;

    always @(negedge clk) begin
        eb = 1'b0; ed = 1'b0; ew = 1'b0;
        ea = 8'h00; ewd = 8'h00;
        pend_v = 1'b0;
        pend_a = 8'h00;
        pend_d = 8'h00;
        if (rst_n && q.size() > 0) begin
            ce = q.pop_front();
            case (ce.k)
                K_RD: begin
                    eb = 1'b1; ea = ce.s;
                end
                K_WR: begin
                    eb = 1'b1; ea = ce.d; ew = 1'b1;
                    ewd = ref_mem[ce.s];
                    pend_v = 1'b1; pend_a = ce.d; pend_d = ewd;
                end
                K_DN: ed = 1'b1;
                default: ;
            endcase
        end
        n_chk++;
        if (bif.busy !== eb || bif.done !== ed ||
            bif.mem_addr !== ea || bif.mem_wr_en !== ew ||
            bif.mem_wdata !== ewd) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t got b=%b d=%b a=%h w=%b wd=%h required b=%b d=%b a=%h w=%b wd=%h",
                     $time, bif.busy, bif.done, bif.mem_addr,
                     bif.mem_wr_en, bif.mem_wdata, eb, ed, ea, ew, ewd);
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h required %h", nm, got, exp);
        end
    endtask

    task automatic poke(logic [7:0] a, logic [7:0] d);
        @(negedge clk); #1;
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Returns #1 after the negedge of copy cycle 1.
    task automatic start_copy(logic [7:0] s, logic [7:0] d,
                              logic [7:0] l);
        @(negedge clk); #1;
        bif.start = 1'b1;
        bif.src_addr = s; bif.dst_addr = d; bif.len = l;
        push_copy(s, d, l);
        @(negedge clk); #1;
        bif.start = 1'b0;
        bif.src_addr = 8'h5C; bif.dst_addr = 8'hEE; bif.len = 8'h07;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) chk("wait_idle_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; clr = 1'b1;
        tb_we = 1'b0; tb_wa = 8'h00; tb_wd = 8'h00;
        bif.start = 1'b0; bif.src_addr = 8'h00;
        bif.dst_addr = 8'h00; bif.len = 8'h00;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        chk("reset_busy", 32'(bif.busy), 32'd0);
        chk("reset_done", 32'(bif.done), 32'd0);
        chk("reset_wr_en", 32'(bif.mem_wr_en), 32'd0);
        chk("reset_addr", 32'(bif.mem_addr), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // Basic copy with ignored start pulses in cycles 3 and 9.
        poke(8'h60, 8'h10); poke(8'h61, 8'hE0);
        poke(8'h62, 8'hF0); poke(8'h63, 8'hCC);
        start_copy(8'h60, 8'd100, 8'd4);
        @(negedge clk); #1;
        @(negedge clk); #1;
        bif.start = 1'b1; bif.src_addr = 8'h33; bif.len = 8'd1;
        @(negedge clk); #1;
        bif.start = 1'b0;
        repeat (5) begin @(negedge clk); #1; end
        bif.start = 1'b1;
        @(negedge clk); #1;
        bif.start = 1'b0;
        wait_idle();
        chk("basic_100", 32'(mem[100]), 32'h10);
        chk("basic_101", 32'(mem[101]), 32'hE0);
        chk("basic_102", 32'(mem[102]), 32'hF0);
        chk("basic_103", 32'(mem[103]), 32'hCC);

        // Empty copy.
        start_copy(8'h60, 8'hC0, 8'd0);
        wait_idle();
        chk("len0_unchanged", 32'(mem[8'hC0]), 32'h43);

        // Source wrap.
        poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB);
        poke(8'h00, 8'hCC); poke(8'h01, 8'hDD);
        start_copy(8'hFE, 8'h10, 8'd4);
        wait_idle();
        chk("swrap_10", 32'(mem[8'h10]), 32'hAA);
        chk("swrap_11", 32'(mem[8'h11]), 32'hBB);
        chk("swrap_12", 32'(mem[8'h12]), 32'hCC);
        chk("swrap_13", 32'(mem[8'h13]), 32'hDD);

        // Destination wrap.
        poke(8'h30, 8'h5A); poke(8'h31, 8'hA5);
        start_copy(8'h30, 8'hFF, 8'd2);
        wait_idle();
        chk("dwrap_ff", 32'(mem[8'hFF]), 32'h5A);
        chk("dwrap_00", 32'(mem[8'h00]), 32'hA5);

        // Overlapping ascending copy.
        poke(8'h20, 8'h01);
        start_copy(8'h20, 8'h21, 8'd3);
        wait_idle();
        chk("ovl_21", 32'(mem[8'h21]), 32'h01);
        chk("ovl_22", 32'(mem[8'h22]), 32'h01);
        chk("ovl_23", 32'(mem[8'h23]), 32'h01);

        // start held: second copy begins in the IDLE after DONE.
        @(negedge clk); #1;
        bif.start = 1'b1;
        bif.src_addr = 8'h60; bif.dst_addr = 8'h80; bif.len = 8'd2;
        push_copy(8'h60, 8'h80, 8'd2);
        @(negedge clk); #1;
        bif.src_addr = 8'h62; bif.dst_addr = 8'h90; bif.len = 8'd2;
        begin
            ent_t e;
            e.k = K_IDLE; e.s = 8'h00; e.d = 8'h00;
            q.push_back(e);
        end
        push_copy(8'h62, 8'h90, 8'd2);
        repeat (6) begin @(negedge clk); #1; end
        bif.start = 1'b0;
        wait_idle();
        chk("hold_80", 32'(mem[8'h80]), 32'h10);
        chk("hold_81", 32'(mem[8'h81]), 32'hE0);
        chk("hold_90", 32'(mem[8'h90]), 32'hF0);
        chk("hold_91", 32'(mem[8'h91]), 32'hCC);

        // Reset during the first WRITE cycle.
        start_copy(8'h60, 8'hB0, 8'd4);
        @(negedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("rst_wr_en", 32'(bif.mem_wr_en), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_dst_unwritten", 32'(mem[8'hB0]), 32'hD3);
        chk("rst_no_resume", 32'(mem[8'hB1]), 32'(patt(8'hB1)));

        n_chk++;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (mem[i] !== ref_mem[i]) bad++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL mem_vs_model got %0d differing bytes required 0",
                         bad);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dat_mem_copier.md
DAT_MEM_COPIER -- requirements
Module: dat_mem_copier

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width in bits.
REQ-002 SHALL have parameter DW, default 8, memory data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, copy request, sampled only in IDLE.
REQ-006 SHALL have port src_addr, input, AW, first source address, captured with start.
REQ-007 SHALL have port dst_addr, input, AW, first destination address, captured with start.
REQ-008 SHALL have port len, input, AW, byte count, captured with start; 0 = empty copy.
REQ-009 SHALL have port busy, output, 1, high while in READ or WRITE.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port mem_addr, output, AW, address driven to the data memory.
REQ-012 SHALL have port mem_wr_en, output, 1, memory write enable; memory writes on posedge clk when high.
REQ-013 SHALL have port mem_wdata, output, DW, write data to memory.
REQ-014 SHALL have port mem_rdata, input, DW, combinational read data, valid in the same cycle as mem_addr.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-016 IDLE: on a clock edge with start=1, SHALL load src_ptr=src_addr, dst_ptr=dst_addr, cnt=len; next state READ if len!=0, else DONE.
REQ-017 READ: mem_addr=src_ptr, mem_wr_en=0; at the clock edge, SHALL capture mem_rdata into data_q and go to WRITE.
REQ-018 WRITE: mem_addr=dst_ptr, mem_wr_en=1, mem_wdata=data_q; at the clock edge, SHALL increment both pointers, decrement cnt, and go to DONE if cnt==1, else READ.
REQ-019 DONE: done=1 for exactly one cycle, then SHALL go to IDLE unconditionally.
REQ-020 In IDLE and DONE: mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-021 Pointer increments SHALL wrap modulo 2^AW (0xFF+1 = 0x00); no error is flagged.
REQ-022 Copy order SHALL be strictly ascending, one read then one write per byte; overlapping regions are copied byte by byte in that order, with no overlap correction.
REQ-023 Latency: for len=L>0 with start at edge E0, the write of byte k SHALL commit at edge E(2k+2), k=0..L-1; done is high in the cycle after E(2L) and busy is low in that cycle.
REQ-024 Latency: for len=0, done SHALL be high in the cycle after E0, with no memory write.
REQ-025 start asserted in READ, WRITE or DONE SHALL be ignored and not queued; inputs src_addr, dst_addr and len may change freely after capture.
REQ-026 Holding start high continuously SHALL produce back-to-back copies, one starting in each IDLE cycle.
REQ-027 Throughput: one byte per 2 cycles; each copy adds 2 cycles of overhead (DONE, IDLE).

Reset
REQ-028 rst_n low SHALL force state IDLE and set src_ptr, dst_ptr, cnt and data_q to 0, asynchronously.
REQ-029 During reset, all outputs SHALL be 0, including mem_wr_en, which drops immediately mid-WRITE so no write occurs at the next edge.
REQ-030 After reset is released mid-copy, the block SHALL not resume; the next copy requires a new start.

Verification
REQ-031 Memory preloaded with [60..63]=10,E0,F0,CC; start with src=60, dst=100, len=4 -> [100..103]=10,E0,F0,CC; done high exactly in cycle 9 after start; busy high for cycles 1-8.
REQ-032 len=0, start -> done pulse in the cycle after start; mem_wr_en never high; memory unchanged.
REQ-033 src=FE, dst=10, len=4, memory [FE]=AA, [FF]=BB, [00]=CC, [01]=DD -> [10..13]=AA,BB,CC,DD (source wrap); a second case with dst=FF checks destination wrap, writing to FF then 00.
REQ-034 Start pulsed again in cycles 3 and 9 of a len=4 copy -> ignored, single done pulse; start held high -> a second copy begins the cycle after DONE.
REQ-035 rst_n low during a WRITE cycle of a len=4 copy -> mem_wr_en is 0 at once, the destination byte is unwritten, the block is in IDLE with busy=0, and there is no done pulse.
REQ-036 Overlapping copy src=20, dst=21, len=3, with [20]=01 -> [21..23]=01,01,01 (ascending propagation).
